// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: instruction geometry and opcodes
package cpu_pkg;

  localparam int INSTR_W_DEFAULT  = 15;
  localparam int OPCODE_W_DEFAULT = 5;

  // Opcodes decoded by the control unit
  localparam logic [OPCODE_W_DEFAULT-1:0] OP_NOP   = 5'h00;
  localparam logic [OPCODE_W_DEFAULT-1:0] OP_LOAD  = 5'h01;
  localparam logic [OPCODE_W_DEFAULT-1:0] OP_STORE = 5'h02;
  localparam logic [OPCODE_W_DEFAULT-1:0] OP_ADD   = 5'h03;
  localparam logic [OPCODE_W_DEFAULT-1:0] OP_SUB   = 5'h04;
  localparam logic [OPCODE_W_DEFAULT-1:0] OP_JUMP  = 5'h08;
  localparam logic [OPCODE_W_DEFAULT-1:0] OP_JZ    = 5'h09;
  localparam logic [OPCODE_W_DEFAULT-1:0] OP_HALT  = 5'h1F;

endpackage

// File: rtl/instr_queue_mem.sv
// rtl/instr_queue_mem.sv - DEPTH x INSTR_W register array, one write port, async read
module instr_queue_mem
  import cpu_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEFAULT,
  parameter int DEPTH   = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Storage: cleared on reset, written one entry per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - first-word-fall-through instruction queue with field split
module instruction_queue
  import cpu_pkg::*;
#(
  parameter int INSTR_W  = INSTR_W_DEFAULT,
  parameter int DEPTH    = 4,
  parameter int OPCODE_W = OPCODE_W_DEFAULT,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INSTR_W-1:0]    out_instr,
  output logic [OPCODE_W-1:0]   out_opcode,
  output logic [INSTR_W-OPCODE_W-1:0] out_operand,
  output logic [CW-1:0]         count,
  output logic                  overrun
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [INSTR_W-1:0] head;
  logic               push;
  logic               pop;

  assign in_ready  = (count < FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  instr_queue_mem #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push && !flush),
    .waddr (wr_ptr),
    .wdata (in_instr),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointers, occupancy and sticky overrun; flush beats any same-cycle push/pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && !in_ready) overrun <= 1'b1;
    end
  end

  assign out_instr   = out_valid ? head : '0;
  assign out_opcode  = out_instr[INSTR_W-1 -: OPCODE_W];
  assign out_operand = out_instr[INSTR_W-OPCODE_W-1:0];

endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - randomized and directed check of instruction_queue against a queue model
module tb_instruction_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_instr;
  logic [4:0]  out_opcode;
  logic [9:0]  out_operand;
  logic [2:0]  count;
  logic        overrun;

  int vectors;
  int miscompares;

  logic [14:0] model_q[$];
  logic        model_overrun;

  instruction_queue dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_opcode  (out_opcode),
    .out_operand (out_operand),
    .count       (count),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int unsigned head;
    head = (model_q.size() != 0) ? 32'(model_q[0]) : 0;
    check_val("out_valid",   32'(out_valid),   32'(model_q.size() != 0));
    check_val("out_instr",   32'(out_instr),   head);
    check_val("out_opcode",  32'(out_opcode),  head / 1024);
    check_val("out_operand", 32'(out_operand), head % 1024);
    check_val("count",       32'(count),       32'(model_q.size()));
    check_val("in_ready",    32'(in_ready),    32'(model_q.size() < DEPTH));
    check_val("overrun",     32'(overrun),     32'(model_overrun));
  endtask

  // Drive one cycle, check outputs for the current state, then advance the model
  task automatic step(input logic iv, input logic [14:0] d, input logic ordy, input logic fl);
    bit can_push, can_pop;
    in_valid  = iv;
    in_instr  = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs();
    can_push = iv && (model_q.size() < DEPTH);
    can_pop  = ordy && (model_q.size() != 0);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
      model_overrun = 1'b0;
    end else begin
      if (iv && model_q.size() == DEPTH) model_overrun = 1'b1;
      if (can_pop) void'(model_q.pop_front());
      if (can_push) model_q.push_back(d);
    end
    #1;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    model_overrun = 1'b0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;

    // Fill and drain, with overrun attempt while full
    step(1, 15'h1234, 0, 0);
    step(1, 15'h0ABC, 0, 0);
    step(1, 15'h7FFF, 0, 0);
    step(1, 15'h0001, 0, 0);
    check_val("full_count", 32'(count), 32'd4);
    check_val("first_opcode", 32'(out_opcode), 32'h04);
    check_val("first_operand", 32'(out_operand), 32'h234);
    step(1, 15'h5555, 0, 0);
    check_val("overrun_set", 32'(overrun), 32'd1);
    check_val("head_after_overrun", 32'(out_instr), 32'h1234);
    repeat (5) step(0, 15'h0, 1, 0);

    // Simultaneous push/pop at count=2 across the pointer wrap
    step(1, 15'h0100, 0, 0);
    step(1, 15'h0101, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 15'(16'h0102 + i), 1, 0);
    check_val("steady_count", 32'(count), 32'd2);
    check_val("steady_head", 32'(out_instr), 32'h0106);

    // Flush priority: count=3 with overrun set
    step(1, 15'h0200, 0, 0);
    step(1, 15'h0201, 0, 0);
    step(1, 15'h0202, 0, 0);
    step(0, 15'h0, 1, 0);
    check_val("pre_flush_count", 32'(count), 32'd3);
    check_val("pre_flush_overrun", 32'(overrun), 32'd1);
    step(1, 15'h0333, 1, 1);
    check_val("post_flush_count", 32'(count), 32'd0);
    check_val("post_flush_overrun", 32'(overrun), 32'd0);
    step(1, 15'h0042, 0, 0);
    check_val("post_flush_head", 32'(out_instr), 32'h0042);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 15'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0);
    end

    // Asynchronous reset mid-operation at count=2
    step(0, 15'h0, 0, 1);
    step(1, 15'h0A0A, 0, 0);
    step(1, 15'h0B0B, 0, 0);
    in_valid = 1'b0;
    check_val("pre_reset_count", 32'(count), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    model_q.delete();
    model_overrun = 1'b0;
    check_val("async_out_valid", 32'(out_valid), 32'd0);
    check_val("async_count", 32'(count), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    step(1, 15'h00FF, 0, 0);
    check_val("post_reset_head", 32'(out_instr), 32'h00FF);
    step(0, 15'h0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
Parametrised successor to the single-stage instruction register. It is a small first-word-fall-through queue between the fetch path and the control unit. It buffers up to DEPTH instructions and presents the head instruction already split into opcode and operand fields. The control unit consumes instructions with a valid/ready handshake, and a flush clears the queue on jumps.

Parameters:
INSTR_W, 15, instruction width in bits
DEPTH, 4, queue entries; power of two, minimum 2
OPCODE_W, 5, opcode field width taken from the MSBs; must be less than INSTR_W

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of all queued instructions
in_valid  in  1  fetch side presents in_instr
in_ready  out  1  queue can accept; high when count < DEPTH
in_instr  in  INSTR_W  instruction from fetch
out_valid  out  1  head instruction available; high when count > 0
out_ready  in  1  control unit consumes the head
out_instr  out  INSTR_W  head instruction; 0 when out_valid=0
out_opcode  out  OPCODE_W  out_instr[INSTR_W-1 : INSTR_W-OPCODE_W]
out_operand  out  INSTR_W-OPCODE_W  out_instr[INSTR_W-OPCODE_W-1 : 0]
count  out  clog2(DEPTH+1)  number of occupied entries
overrun  out  1  sticky flag: a push was attempted while full

Behaviour:
- Reset (asynchronous, reset=1):
  - rd_ptr, wr_ptr, count and overrun go to 0; all storage entries go to 0.
  - Outputs: out_valid=0, out_instr=0, in_ready=1.
  - Applies immediately, including mid-operation; no in-flight push or pop survives.
- Push: in_valid && in_ready at the clock edge.
  - Write mem[wr_ptr]; wr_ptr increments modulo DEPTH (natural wrap, DEPTH is a power of two).
- Pop: out_valid && out_ready at the clock edge.
  - rd_ptr increments modulo DEPTH.
- count update:
  - count+1 on push only; count-1 on pop only; unchanged on both or neither.
- Latency:
  - An instruction pushed at edge N appears on out_instr/out_valid after edge N; no combinational in-to-out path.
  - out_instr, out_opcode and out_operand are combinational from registered state (head entry masked with out_valid).
- Full (count=DEPTH):
  - in_ready=0 regardless of out_ready; no same-cycle pass-through.
  - in_valid=1 in this state sets overrun=1 at the edge; in_instr is discarded and the pointers do not move.
- Empty (count=0):
  - out_valid=0; out_ready is ignored.
  - A push in this cycle is visible next cycle.
- Simultaneous push and pop with 0<count<DEPTH: both occur, count is unchanged, and ordering is preserved.
- flush=1 at the edge:
  - rd_ptr, wr_ptr, count and overrun go to 0; out_valid=0 next cycle.
  - flush overrides any same-cycle push or pop; the pushed word is dropped and no overrun is set.
  - Storage contents need not be cleared.
- overrun:
  - Cleared only by reset or flush.
  - Never affects queue contents.
- Field split:
  - Pure bit slicing, no sign extension.
  - Both fields read 0 when empty.

Decomposition:
- Shared package (cpu_pkg), constants only:
  - INSTR_W_DEFAULT=15, OPCODE_W_DEFAULT=5;
  - opcode localparams for the control unit.
- Queue-specific logic stays local to this module.
- One natural sub-module, instr_queue_mem: the DEPTH x INSTR_W register array.
  - Write port (we, waddr, wdata) and asynchronous read port (raddr).
  - Asynchronous reset to zero.
- Pointers, count, flags and field slicing live in instruction_queue.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with in_valid=0 -> out_valid=0, out_instr=0, in_ready=1, count=0, overrun=0.
- Fill and drain: push 0x1234, 0x0ABC, 0x7FFF, 0x0001 with out_ready=0, then out_ready=1.
  - After the 4th push: count=4 and in_ready=0.
  - Pops return the same order.
  - First head: out_opcode=0x1234>>10=0x04, out_operand=0x234.
- Overrun when full: push 0x5555 while count=4 -> overrun=1, count stays 4, and head plus drain order are unchanged (0x5555 never appears).
- Simultaneous push/pop at count=2 for 6 cycles with an incrementing pattern -> count stays 2, pointers wrap past DEPTH-1 with no lost or duplicated word, and output order equals input order.
- Flush priority: count=3, overrun=1, and flush=1 in the same cycle as in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, overrun=0; a push of 0x0042 one cycle later is the next head.
- Async reset mid-operation: assert reset between clock edges while count=2 -> out_valid=0 and count=0 before the next edge; after deassert, a push of 0x00FF becomes the head.
